// File: rtl/pin_byte_packer.sv
// Packs consecutive pin-side bytes into little-endian words and queues them in a
// small registered FIFO toward the FFT, carrying frame end and flagging short frames.
module pin_byte_packer #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic                        out_last,
  output logic                        short_frame
);

  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
  localparam int unsigned ENT_W  = WORD_W + 1;
  localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [WORD_W-1:0] asm_q, asm_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_n [FIFO_DEPTH];
  logic              valid_q, full_q, short_q, short_n;

  logic              accept, push, pop;
  logic [WORD_W-1:0] word_c;
  logic [CNT_W-1:0]  wpos;

  // Readiness depends only on registered fullness, held low through reset.
  assign in_ready    = ~reset & ~full_q;
  assign out_valid   = valid_q;
  assign out_data    = mem_q[0][WORD_W-1:0];
  assign out_last    = mem_q[0][WORD_W];
  assign short_frame = short_q;

  always_comb begin
    idx_n   = idx_q;
    asm_n   = asm_q;
    mem_n   = mem_q;
    cnt_n   = cnt_q;
    short_n = short_q;
    word_c  = asm_q;

    accept = in_valid & in_ready;
    pop    = valid_q & out_ready;

    // Merge the incoming byte into its slot; unwritten upper slots stay zero.
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (idx_q == IDX_W'(k)) word_c[8*k +: 8] = in_data;
    end

    push = accept & (in_last | (idx_q == IDX_MAX));

    if (accept) begin
      if (push) begin
        idx_n = '0;
        asm_n = '0;
      end else begin
        idx_n = idx_q + IDX_W'(1);
        asm_n = word_c;
      end
      if (in_last && (idx_q != IDX_MAX)) short_n = 1'b1;
    end

    // Shift-register FIFO: slot 0 is always the head, so outputs come straight off flops.
    if (pop) begin
      for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) mem_n[i] = mem_q[i+1];
    end

    wpos = cnt_q - CNT_W'(pop);
    if (push) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (wpos == CNT_W'(i)) mem_n[i] = {in_last, word_c};
      end
    end

    cnt_n = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      short_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      idx_q   <= idx_n;
      asm_q   <= asm_n;
      cnt_q   <= cnt_n;
      valid_q <= (cnt_n != '0);
      full_q  <= (cnt_n == CNT_FULL);
      short_q <= short_n;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_n[i];
    end
  end

endmodule

// File: tb/tb_pin_byte_packer.sv
// Directed bench for pin_byte_packer: a vector table for packing, frame end and
// push/pop overlap, plus hand sequences for backpressure and mid-word reset.
module tb_pin_byte_packer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        short_frame;

  int n_tests = 0;
  int n_fail  = 0;

  pin_byte_packer #(.BYTES_PER_WORD(4), .FIFO_DEPTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .short_frame(short_frame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        r;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_sf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic r,
                              logic e_ir, logic e_ov, logic [31:0] e_data,
                              logic e_last, logic e_sf);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_data = e_data; t.e_last = e_last; t.e_sf = e_sf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector before the edge, check the state it produced just after the edge.
  task automatic apply(input vec_t t, input int i);
    @(negedge clock);
    in_valid  = t.v;
    in_data   = t.d;
    in_last   = t.l;
    out_ready = t.r;
    @(posedge clock);
    #1;
    chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(t.e_ir));
    chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(t.e_ov));
    chk($sformatf("vec%0d.short_frame", i), 32'(short_frame), 32'(t.e_sf));
    if (t.e_ov) begin
      chk($sformatf("vec%0d.out_data", i), out_data, t.e_data);
      chk($sformatf("vec%0d.out_last", i), 32'(out_last), 32'(t.e_last));
    end
  endtask

  // Present one byte until accepted, bounded.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(0), 32'(1));
    @(posedge clock);
  endtask

  logic [31:0] exp_words [3];
  int          bi;
  int          widx;
  int          cyc;
  logic        acc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.in_ready", 32'(in_ready), 32'(0));
    chk("rst.out_valid", 32'(out_valid), 32'(0));
    chk("rst.out_data", out_data, 32'h0);
    chk("rst.out_last", 32'(out_last), 32'(0));
    chk("rst.short_frame", 32'(short_frame), 32'(0));
    reset = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'(1));

    // Basic pack
    vecs.push_back(mk(1, 8'h04, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 1, 1, 1, 32'h01020304, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 0));
    // Frame end on a word boundary
    vecs.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h12, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h13, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h14, 0, 1, 1, 1, 32'h14131211, 0, 0));
    vecs.push_back(mk(1, 8'h15, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h16, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h17, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'h18, 1, 1, 1, 1, 32'h18171615, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 0));
    // Short frame, then a normal word with the flag still set
    vecs.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 1, 1));
    vecs.push_back(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 8'h04, 0, 1, 1, 1, 32'h04030201, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 1));
    // Simultaneous push and pop with one word held
    vecs.push_back(mk(1, 8'h21, 0, 0, 1, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 8'h22, 0, 0, 1, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 8'h23, 0, 0, 1, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 8'h24, 0, 0, 1, 1, 32'h24232221, 0, 1));
    vecs.push_back(mk(1, 8'h31, 0, 0, 1, 1, 32'h24232221, 0, 1));
    vecs.push_back(mk(1, 8'h32, 0, 0, 1, 1, 32'h24232221, 0, 1));
    vecs.push_back(mk(1, 8'h33, 0, 0, 1, 1, 32'h24232221, 0, 1));
    vecs.push_back(mk(1, 8'h34, 0, 1, 1, 1, 32'h34333231, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Backpressure: fill both slots, then stall with a byte pending
    out_ready = 1'b0;
    for (int b = 0; b < 8; b++) send(8'(b), 1'b0);
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'h08; in_last = 1'b0;
    chk("bp.in_ready_full", 32'(in_ready), 32'(0));
    chk("bp.out_valid", 32'(out_valid), 32'(1));
    chk("bp.head", out_data, 32'h03020100);
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      chk($sformatf("bp.stall%0d.in_ready", s), 32'(in_ready), 32'(0));
      chk($sformatf("bp.stall%0d.out_data", s), out_data, 32'h03020100);
    end

    exp_words[0] = 32'h03020100;
    exp_words[1] = 32'h07060504;
    exp_words[2] = 32'h0B0A0908;
    bi = 8; widx = 0; cyc = 0;
    while (widx < 3 && cyc < 40) begin
      @(negedge clock);
      out_ready = 1'b1;
      if (out_valid) begin
        chk($sformatf("bp.word%0d", widx), out_data, exp_words[widx]);
        widx++;
      end
      in_valid = (bi < 12);
      in_data  = 8'(bi);
      acc = in_valid && in_ready;
      @(posedge clock);
      if (acc) bi++;
      cyc++;
    end
    chk("bp.words_drained", 32'(widx), 32'(3));
    chk("bp.bytes_taken", 32'(bi), 32'(12));
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp.no_dup", 32'(out_valid), 32'(0));

    // Reset mid-word with a stored word and a partial word pending
    out_ready = 1'b0;
    send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b0);
    send(8'h51, 1'b0); send(8'h52, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst.in_ready", 32'(in_ready), 32'(0));
    chk("mrst.out_valid", 32'(out_valid), 32'(0));
    chk("mrst.short_frame", 32'(short_frame), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    chk("mrst.out_valid", 32'(out_valid), 32'(1));
    chk("mrst.word", out_data, 32'h04030201);
    chk("mrst.out_last", 32'(out_last), 32'(0));
    chk("mrst.short_frame_after", 32'(short_frame), 32'(0));
    @(negedge clock);
    chk("mrst.drained", 32'(out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
